counter_arbiter: RTL and testbench
==================================

COUNTER_ARBITER -- requirements
Module: counter_arbiter

Interface
REQ-001 The block SHALL have one clock, and its reset SHALL be synchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-low reset, sampled on rising clk.
REQ-004 req  input  2  per-requester interval request; bit i is requester i; level, held until done[i] or abort.
REQ-005 len0  input  4  requested interval length for requester 0; sampled only at grant.
REQ-006 len1  input  4  requested interval length for requester 1; sampled only at grant.
REQ-007 count_in  input  4  count value from the shared 4-bit up-counter (sync active-high reset, enable, +1 per enabled clk).
REQ-008 cnt_reset  output  1  drives the shared counter's reset.
REQ-009 cnt_enable  output  1  drives the shared counter's enable.
REQ-010 gnt  output  2  one-hot grant; at most one bit set.
REQ-011 done  output  2  one-cycle completion pulse to the granted requester.
REQ-012 busy  output  1  high whenever state is not IDLE.

Function
REQ-013 The FSM SHALL have states IDLE, CLEAR, RUN and DONE, held in registers; all outputs SHALL be decoded from registered state, except cnt_reset.
REQ-014 IDLE with req==0 SHALL stay IDLE; gnt=0, cnt_enable=0, cnt_reset=0.
REQ-015 IDLE with any req bit set SHALL, at the next edge:
  - select one requester;
  - load gnt_q one-hot;
  - latch that requester's len into len_q;
  - set last_q to the winner;
  - go to CLEAR.
REQ-016 Selection SHALL be round-robin: a single requester wins; when req==2'b11, the requester not equal to last_q wins.
REQ-017 CLEAR SHALL last exactly one cycle with cnt_reset=1 and cnt_enable=0, then go to RUN.
REQ-018 RUN SHALL drive cnt_enable=1 while count_in!=len_q, and cnt_enable=0 when count_in==len_q.
REQ-019 RUN with count_in==len_q SHALL go to DONE at the next edge.
REQ-020 RUN SHALL last len_q+1 cycles.
REQ-021 DONE SHALL last one cycle with done=gnt_q and cnt_enable=0, then go to IDLE.
REQ-022 done SHALL be 0 in every state other than DONE.
REQ-023 gnt SHALL equal gnt_q in CLEAR, RUN and DONE, and SHALL be 0 in IDLE.
REQ-024 Latency SHALL be fixed: gnt first visible in cycle G, done[i] pulsed in cycle G+len_q+2.
REQ-025 len_q=0 SHALL be legal: RUN lasts one cycle with cnt_enable=0, and done follows.
REQ-026 len_q=15 SHALL stop at count 15; the counter SHALL never wrap under arbiter control.
REQ-027 Abort: if the granted req bit drops in CLEAR or RUN, the FSM SHALL go to IDLE at the next edge:
  - no done pulse is issued;
  - cnt_enable is 0 from that next cycle;
  - last_q is kept.
REQ-028 A non-granted req asserted or dropped during CLEAR/RUN/DONE SHALL have no effect until IDLE.
REQ-029 Requester i re-requesting in the cycle after done[i] SHALL be arbitrated normally from IDLE; the other requester, if pending, wins by round-robin.
REQ-030 len0/len1 changes after grant SHALL NOT affect len_q.

Reset
REQ-031 reset==0 at a rising edge SHALL force state=IDLE, gnt_q=0, len_q=0, last_q=1 (requester 0 wins first tie).
REQ-032 cnt_reset SHALL equal (state==CLEAR) OR (reset==0), combinationally, so the shared counter clears alongside the arbiter.
REQ-033 While reset==0: gnt=0, done=0, busy=0, cnt_enable=0.
REQ-034 Reset asserted mid-RUN SHALL abort without a done pulse; the first grant after reset release follows REQ-031.

Verification
REQ-035 Single request: reset, then req=01, len0=5 -> gnt=01 next cycle; CLEAR one cycle; cnt_enable high 5 cycles; done[0] pulse 7 cycles after gnt; busy low after.
REQ-036 Tie fairness: req=11, len0=2, len1=3, both held, re-raised after done -> grant order 0,1,0,1; no cycle with both gnt bits set.
REQ-037 Zero length: req=10, len1=0 -> cnt_enable never high; done[1] 2 cycles after gnt.
REQ-038 Max length and no wrap: req=01, len0=15 -> count_in reaches 15 and holds; done[0] 17 cycles after gnt.
REQ-039 Abort: req[0] dropped when count_in=3 (len0=8) -> next cycle IDLE, cnt_enable=0, no done; a pending req[1] is granted the following cycle.
REQ-040 Reset mid-operation: reset=0 during RUN -> cnt_reset=1 same cycle; gnt=0 and busy=0 after edge; after release with req=11, requester 0 is granted.

Source files
------------

// File: rtl/counter_arbiter.sv
// Round-robin arbiter granting two requesters timed intervals on a shared 4-bit up-counter.
// The counter is held in reset for one cycle per grant and then enabled until it reaches the latched length.
module counter_arbiter (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic [3:0] len0,
    input  logic [3:0] len1,
    input  logic [3:0] count_in,
    output logic       cnt_reset,
    output logic       cnt_enable,
    output logic [1:0] gnt,
    output logic [1:0] done,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] gnt_q, gnt_d;
    logic [3:0] len_q, len_d;
    logic       last_q, last_d;

    logic       winner;
    logic       granted_held;
    logic       at_len;

    // On a tie the requester that did not win last time goes next.
    always_comb begin
        if (req == 2'b11) begin
            winner = ~last_q;
        end else begin
            winner = req[1];
        end
    end

    assign granted_held = |(req & gnt_q);
    assign at_len       = (count_in == len_q);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        len_d   = len_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    gnt_d   = winner ? 2'b10 : 2'b01;
                    len_d   = winner ? len1 : len0;
                    last_d  = winner;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                state_d = granted_held ? RUN : IDLE;
            end
            RUN: begin
                // A dropped request wins over completion: no done for an abandoned interval.
                if (!granted_held) begin
                    state_d = IDLE;
                end else if (at_len) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            len_q   <= '0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            len_q   <= len_d;
            last_q  <= last_d;
        end
    end

    // Outputs are masked by the reset input so they drop in the same cycle reset is asserted.
    always_comb begin
        busy       = reset && (state_q != IDLE);
        gnt        = (reset && (state_q != IDLE)) ? gnt_q : '0;
        done       = (reset && (state_q == DONE)) ? gnt_q : '0;
        cnt_enable = reset && (state_q == RUN) && !at_len;
        cnt_reset  = !reset || (state_q == CLEAR);
    end

endmodule

// File: tb/tb_counter_arbiter.sv
// Self-checking bench for counter_arbiter with a behavioural model of the shared counter
// and a queue of expected grants/completions.
module tb_counter_arbiter;

    logic       clk;
    logic       reset;
    logic [1:0] req;
    logic [3:0] len0;
    logic [3:0] len1;
    logic [3:0] count_in;
    logic       cnt_reset;
    logic       cnt_enable;
    logic [1:0] gnt;
    logic [1:0] done;
    logic       busy;

    typedef struct {
        int who;
        int len;
    } exp_t;

    exp_t sb[$];
    int   n_checks;
    int   n_fail;
    int   cyc;
    int   g_cyc;

    counter_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .len0       (len0),
        .len1       (len1),
        .count_in   (count_in),
        .cnt_reset  (cnt_reset),
        .cnt_enable (cnt_enable),
        .gnt        (gnt),
        .done       (done),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Shared 4-bit up-counter: sync active-high reset, enable.
    always @(posedge clk) begin
        if (cnt_reset) count_in <= 4'd0;
        else if (cnt_enable) count_in <= count_in + 4'd1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [1:0] onehot(input int who);
        return (who == 1) ? 2'b10 : 2'b01;
    endfunction

    // Waits for the grant expected at the head of the scoreboard; gdelay is cycles from now.
    task automatic wait_gnt(input int gdelay, input string name);
        exp_t e;
        int   r;
        bit   seen;
        r    = cyc;
        seen = 0;
        e    = sb[0];
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (gnt != 2'b00) seen = 1;
        end
        g_cyc = cyc;
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s_gnt_timeout: no grant within 10 cycles", name);
        end else begin
            n_checks++;
            if (gnt !== onehot(e.who)) begin
                n_fail++;
                $display("FAIL %s_gnt: got %b expected %b", name, gnt, onehot(e.who));
            end
            n_checks++;
            if (cyc - r !== gdelay) begin
                n_fail++;
                $display("FAIL %s_gnt_latency: got %0d expected %0d", name, cyc - r, gdelay);
            end
            n_checks++;
            if (cnt_reset !== 1'b1 || cnt_enable !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL %s_clear: got rst=%b en=%b busy=%b expected rst=1 en=0 busy=1",
                         name, cnt_reset, cnt_enable, busy);
            end
        end
    endtask

    task automatic wait_done(input string name);
        exp_t e;
        int   en;
        int   i;
        bit   seen;
        bit   both;
        e    = sb.pop_front();
        en   = 0;
        seen = 0;
        both = 0;
        i    = 0;
        while (!seen && i < 40) begin
            @(negedge clk);
            if (gnt == 2'b11) both = 1;
            if (done != 2'b00) seen = 1;
            else if (cnt_enable) en++;
            i++;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s_done_timeout: no done within 40 cycles", name);
        end else begin
            n_checks++;
            if (done !== onehot(e.who)) begin
                n_fail++;
                $display("FAIL %s_done: got %b expected %b", name, done, onehot(e.who));
            end
            n_checks++;
            if (cyc - g_cyc !== e.len + 2) begin
                n_fail++;
                $display("FAIL %s_done_latency: got %0d expected %0d", name, cyc - g_cyc, e.len + 2);
            end
            n_checks++;
            if (en !== e.len) begin
                n_fail++;
                $display("FAIL %s_enable_cycles: got %0d expected %0d", name, en, e.len);
            end
            n_checks++;
            if (count_in !== 4'(e.len) || cnt_enable !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_final_count: got count=%0d en=%b expected count=%0d en=0",
                         name, count_in, cnt_enable, e.len);
            end
        end
        n_checks++;
        if (both) begin
            n_fail++;
            $display("FAIL %s_gnt_onehot: got 11 expected at most one bit", name);
        end
    endtask

    task automatic check_idle(input string name);
        n_checks++;
        if (busy !== 1'b0 || gnt !== 2'b00 || done !== 2'b00 || cnt_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_idle: got busy=%b gnt=%b done=%b en=%b expected all 0",
                     name, busy, gnt, done, cnt_enable);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req   = 2'b00;
        len0  = 4'd0;
        len1  = 4'd0;
        repeat (2) @(negedge clk);
        check_idle("reset_hold");
        n_checks++;
        if (cnt_reset !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_cnt_reset: got %b expected 1", cnt_reset);
        end
        reset = 1'b1;
        @(negedge clk);
        check_idle("reset_release");
        n_checks++;
        if (cnt_reset !== 1'b0 || count_in !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_release_cnt: got rst=%b count=%0d expected rst=0 count=0",
                     cnt_reset, count_in);
        end
    endtask

    task automatic test_tie();
        int order[4] = '{0, 1, 0, 1};
        req  = 2'b11;
        len0 = 4'd2;
        len1 = 4'd3;
        for (int k = 0; k < 4; k++) begin
            sb.push_back('{who: order[k], len: (order[k] == 1) ? 3 : 2});
            wait_gnt((k == 0) ? 1 : 2, "tie");
            wait_done("tie");
        end
        req = 2'b00;
        @(negedge clk);
        check_idle("tie_end");
    endtask

    task automatic test_single();
        req  = 2'b01;
        len0 = 4'd5;
        sb.push_back('{who: 0, len: 5});
        wait_gnt(1, "single");
        wait_done("single");
        req = 2'b00;
        @(negedge clk);
        check_idle("single_end");
    endtask

    task automatic test_zero_len();
        req  = 2'b10;
        len1 = 4'd0;
        sb.push_back('{who: 1, len: 0});
        wait_gnt(1, "zero");
        wait_done("zero");
        req = 2'b00;
        @(negedge clk);
        check_idle("zero_end");
    endtask

    task automatic test_max_len();
        req  = 2'b01;
        len0 = 4'd15;
        sb.push_back('{who: 0, len: 15});
        wait_gnt(1, "max");
        wait_done("max");
        req = 2'b00;
        @(negedge clk);
        check_idle("max_end");
        n_checks++;
        if (count_in !== 4'd15) begin
            n_fail++;
            $display("FAIL max_no_wrap: got %0d expected 15", count_in);
        end
    endtask

    task automatic test_abort();
        bit found;
        bit early_done;
        req  = 2'b01;
        len0 = 4'd8;
        len1 = 4'd4;
        sb.push_back('{who: 0, len: 8});
        wait_gnt(1, "abort");
        req        = 2'b11;
        found      = 0;
        early_done = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (done != 2'b00) early_done = 1;
            if (count_in == 4'd3) found = 1;
        end
        n_checks++;
        if (!found || early_done || gnt !== 2'b01) begin
            n_fail++;
            $display("FAIL abort_reach3: got found=%b done_seen=%b gnt=%b expected 1 0 01",
                     found, early_done, gnt);
        end
        void'(sb.pop_front());
        req = 2'b10;
        @(negedge clk);
        check_idle("abort_next");
        sb.push_back('{who: 1, len: 4});
        wait_gnt(1, "abort_pending");
        len1 = 4'd9;
        wait_done("abort_pending");
        req = 2'b00;
        @(negedge clk);
        check_idle("abort_end");
    endtask

    task automatic test_reset_mid();
        req  = 2'b01;
        len0 = 4'd10;
        sb.push_back('{who: 0, len: 10});
        wait_gnt(1, "rstmid");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check_idle("rstmid_same");
        n_checks++;
        if (cnt_reset !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_cnt_reset: got %b expected 1", cnt_reset);
        end
        void'(sb.pop_front());
        @(negedge clk);
        check_idle("rstmid_after");
        n_checks++;
        if (count_in !== 4'd0) begin
            n_fail++;
            $display("FAIL rstmid_count: got %0d expected 0", count_in);
        end
        reset = 1'b1;
        req   = 2'b11;
        len0  = 4'd3;
        sb.push_back('{who: 0, len: 3});
        wait_gnt(1, "rstmid_first");
        wait_done("rstmid_first");
        req = 2'b00;
        @(negedge clk);
        check_idle("rstmid_end");
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        g_cyc    = 0;
        test_reset();
        test_tie();
        test_single();
        test_zero_len();
        test_max_len();
        test_abort();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
